// File: rtl/mem_initiator.sv
// Single-outstanding memory-bus initiator: accepts one command, drives a registered
// select/address/data access, waits for mem_valid and returns one response.
// Optional ACCESS-phase watchdog is compiled in with `define MEM_INITIATOR_TIMEOUT_EN.
module mem_initiator #(
  parameter int ADDR_W         = 16,
  parameter int DATA_W         = 16,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rstn,
  // Command channel, accepted on an edge where cmd_valid && cmd_ready.
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_wnr,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  // Response channel, completes on an edge where rsp_valid && rsp_ready;
  // rsp_valid and its payload stay stable until then.
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_wnr,
  output logic              rsp_err,
  // Memory bus
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wnr,
  output logic              mem_select,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_valid,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q;
  logic                cmd_ready_q;
  logic                busy_q;
  logic                mem_select_q;
  logic                mem_wnr_q;
  logic [ADDR_W-1:0]   mem_address_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic                rsp_valid_q;
  logic [DATA_W-1:0]   rsp_rdata_q;
  logic                rsp_wnr_q;

`ifdef MEM_INITIATOR_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0]    cnt_q;
  logic                rsp_err_q;
`else
  logic [31:0]         timeout_unused;
  assign timeout_unused = TIMEOUT_CYCLES;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      cmd_ready_q   <= 1'b0;
      busy_q        <= 1'b0;
      mem_select_q  <= 1'b0;
      mem_wnr_q     <= 1'b0;
      mem_address_q <= '0;
      mem_wdata_q   <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_wnr_q     <= 1'b0;
`ifdef MEM_INITIATOR_TIMEOUT_EN
      cnt_q         <= '0;
      rsp_err_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q       <= ACCESS;
            cmd_ready_q   <= 1'b0;
            busy_q        <= 1'b1;
            mem_select_q  <= 1'b1;
            mem_wnr_q     <= cmd_wnr;
            mem_address_q <= cmd_addr;
            mem_wdata_q   <= cmd_wdata;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            cnt_q         <= '0;
`endif
          end else begin
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
          end
        end

        ACCESS: begin
          // Select must fall on the same edge that sees mem_valid, otherwise
          // the responder treats the still-high select as a new access.
          if (mem_valid) begin
            state_q      <= RESP;
            mem_select_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_wnr_q    <= mem_wnr_q;
            rsp_rdata_q  <= mem_wnr_q ? '0 : mem_rdata;
`ifdef MEM_INITIATOR_TIMEOUT_EN
            rsp_err_q    <= 1'b0;
`endif
          end
`ifdef MEM_INITIATOR_TIMEOUT_EN
          else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            state_q      <= RESP;
            mem_select_q <= 1'b0;
            rsp_valid_q  <= 1'b1;
            rsp_wnr_q    <= mem_wnr_q;
            rsp_rdata_q  <= '0;
            rsp_err_q    <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
`endif
        end

        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end

        default: begin
          state_q      <= IDLE;
          mem_select_q <= 1'b0;
          rsp_valid_q  <= 1'b0;
          busy_q       <= 1'b0;
          cmd_ready_q  <= 1'b1;
        end
      endcase
    end
  end

  assign cmd_ready   = cmd_ready_q;
  assign busy        = busy_q;
  assign mem_select  = mem_select_q;
  assign mem_wnr     = mem_wnr_q;
  assign mem_address = mem_address_q;
  assign mem_wdata   = mem_wdata_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_wnr     = rsp_wnr_q;
  assign dbg_state   = state_q;

`ifdef MEM_INITIATOR_TIMEOUT_EN
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

endmodule

// File: doc/mem_initiator.md
MEM_INITIATOR -- requirements
Module: mem_initiator

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, width of command and memory address.
REQ-002 SHALL have parameter DATA_W, default 16, width of write/read data.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 15, ACCESS-state cycles before abort (used only with MEM_INITIATOR_TIMEOUT_EN).
REQ-004 SHALL have ports: clk  in  1  sole clock, rising edge.
REQ-005 SHALL have ports: rstn  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have ports: cmd_valid  in  1  command offered.
REQ-007 SHALL have ports: cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clk edge.
REQ-008 SHALL have ports: cmd_wnr  in  1  1 = write, 0 = read.
REQ-009 SHALL have ports: cmd_addr  in  ADDR_W  word address.
REQ-010 SHALL have ports: cmd_wdata  in  DATA_W  write data.
REQ-011 SHALL have ports: rsp_valid / rsp_ready  out / in  1 / 1  response handshake.
REQ-012 SHALL have ports: rsp_rdata  out  DATA_W  read data (0 for writes and errors).
REQ-013 SHALL have ports: rsp_wnr, rsp_err  out  1 each  echoed command type; timeout flag.
REQ-014 SHALL have ports: mem_address, mem_wdata  out  ADDR_W, DATA_W  memory-bus address/data.
REQ-015 SHALL have ports: mem_wnr, mem_select  out  1 each  memory-bus direction and request strobe.
REQ-016 SHALL have ports: mem_rdata, mem_valid  in  DATA_W, 1  memory-bus read data and completion pulse.
REQ-017 SHALL have ports: busy  out  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM with states IDLE, ACCESS, RESP; all memory-bus outputs registered.
REQ-019 SHALL assert cmd_ready only in IDLE; on accept, latch addr/wdata/wnr onto mem_* outputs, set mem_select=1, enter ACCESS.
REQ-020 SHALL hold mem_select and mem_address/mem_wdata/mem_wnr stable throughout ACCESS.
REQ-021 SHALL, in ACCESS at the edge sampling mem_valid=1, clear mem_select at that same edge (responder re-issues the access if select stays high after its valid pulse) and enter RESP.
REQ-022 SHALL capture mem_rdata into rsp_rdata at that edge for reads; rsp_rdata=0 for writes.
REQ-023 SHALL give minimum latency: accept at edge N, mem_select high N..N+1, mem_valid sampled at N+2, rsp_valid high after N+2.
REQ-024 SHALL hold rsp_valid, rsp_rdata, rsp_wnr, rsp_err stable in RESP until rsp_ready=1; then return to IDLE.
REQ-025 SHALL allow the next command accept in the cycle after RESP exits; back-to-back select gap is >=1 cycle low.
REQ-026 SHALL ignore mem_valid in IDLE and RESP (stray or late pulses).
REQ-027 SHALL ignore cmd_valid outside IDLE; no command queueing.

Reset
REQ-028 SHALL, on rstn low, asynchronously force state IDLE, mem_select=0, mem_wnr=0, mem_address=0, mem_wdata=0, rsp_valid=0, rsp_rdata=0, rsp_wnr=0, rsp_err=0, busy=0, timeout counter=0.
REQ-029 SHALL abandon any in-flight access on reset without a response; cmd_ready=1 from the first edge after rstn rises.

Configuration
REQ-030 SHALL, with MEM_INITIATOR_TIMEOUT_EN defined, count ACCESS cycles; on reaching TIMEOUT_CYCLES without mem_valid, clear mem_select, enter RESP with rsp_err=1, rsp_rdata=0.
REQ-031 SHALL, with MEM_INITIATOR_TIMEOUT_EN defined, give mem_valid priority when it arrives in the same cycle the count reaches TIMEOUT_CYCLES (rsp_err=0).
REQ-032 SHALL, without MEM_INITIATOR_TIMEOUT_EN, omit the counter, tie rsp_err to 0 and wait in ACCESS indefinitely.

Verification
REQ-033 SHALL cover: write addr 0x0005 data 0xBEEF, then read 0x0005 -> rsp_rdata=0xBEEF, rsp_wnr=0, rsp_err=0; write response rsp_rdata=0.
REQ-034 SHALL cover: read accepted at edge N with rsp_ready=1 -> mem_select high exactly 2 cycles, rsp_valid high 1 cycle after edge N+2, single mem_valid pulse per access.
REQ-035 SHALL cover: rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, cmd_ready=0, cmd_valid ignored, no mem_select.
REQ-036 SHALL cover: rstn pulsed low while in ACCESS -> mem_select=0 immediately (before next edge), no rsp_valid, next command completes normally.
REQ-037 SHALL cover: with MEM_INITIATOR_TIMEOUT_EN and TIMEOUT_CYCLES=4, mem_valid held 0 -> mem_select drops after 4 ACCESS cycles, rsp_err=1, rsp_rdata=0; later stray mem_valid ignored.
REQ-038 SHALL cover: 16 back-to-back random read/write commands to addresses 0x000-0xFFF against the memory model -> every read returns last written value, no duplicate accesses.
